// File: rtl/stream_mux_arb_if.sv
// Stream bundle between the N:1 multiplexer and its producers/consumer.
// master = the side that drives the channel inputs; slave = the mux itself.
interface stream_mux_arb_if #(
    parameter int WIDTH  = 17,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2
);
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_last;
    logic [NUM_CH-1:0]       in_ready;
    logic [SEL_W-1:0]        select;
    logic [WIDTH-1:0]        out_data;
    logic                    out_last;
    logic [SEL_W-1:0]        out_ch;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output in_data, in_valid, in_last, select, out_ready,
        input  in_ready, out_data, out_last, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, in_last, select, out_ready,
        output in_ready, out_data, out_last, out_ch, out_valid
    );
endinterface

// File: rtl/stream_mux_arb.sv
// Registered N:1 stream multiplexer with packet locking on in_last and
// either select-driven (MODE=0) or round-robin (MODE=1) channel arbitration.
module stream_mux_arb #(
    parameter int WIDTH  = 17,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = 2,
    parameter int MODE   = 0
) (
    input  logic            clk,
    input  logic            reset,
    stream_mux_arb_if.slave bus
);
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t           state, state_nxt;
    logic [SEL_W-1:0] lock_ch;
    logic [SEL_W-1:0] rr_ptr;
    logic [SEL_W-1:0] grant;
    logic             grant_ok;
    logic             can_load;
    logic             xfer;
    logic             sel_valid;
    logic             sel_last;
    logic [WIDTH-1:0] sel_data;

    logic [WIDTH-1:0] data_p1;
    logic             last_p1;
    logic [SEL_W-1:0] ch_p1;
    logic             vld_p1;

    assign can_load = !vld_p1 || bus.out_ready;

    always_comb begin : grant_logic
        logic found;
        int   idx;
        grant    = '0;
        grant_ok = 1'b0;
        found    = 1'b0;
        idx      = 0;
        if (state == LOCKED) begin
            grant    = lock_ch;
            grant_ok = 1'b1;
        end else if (MODE == 0) begin
            // Looping over channels keeps an out-of-range select from indexing past in_valid.
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(bus.select) == k && bus.in_valid[k]) begin
                    grant    = SEL_W'(k);
                    grant_ok = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= NUM_CH; i++) begin
                idx = (int'(rr_ptr) + i) % NUM_CH;
                if (!found && bus.in_valid[idx]) begin
                    found    = 1'b1;
                    grant    = SEL_W'(idx);
                    grant_ok = 1'b1;
                end
            end
        end
    end

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant == SEL_W'(k)) begin
                sel_data  = bus.in_data[k*WIDTH +: WIDTH];
                sel_valid = bus.in_valid[k];
                sel_last  = bus.in_last[k];
            end
        end
    end

    assign xfer = grant_ok && can_load && sel_valid;

    always_comb begin
        bus.in_ready = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_ok && can_load && grant == SEL_W'(k)) begin
                bus.in_ready[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer && !sel_last) state_nxt = LOCKED;
            LOCKED:  if (xfer && sel_last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_ch <= '0;
            rr_ptr  <= SEL_W'(NUM_CH - 1);
        end else begin
            if (xfer && state == IDLE && !sel_last) begin
                lock_ch <= grant;
            end
            if (xfer && sel_last) begin
                rr_ptr <= grant;
            end
        end
    end

    // Stage p1: output register; drain and reload happen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            last_p1 <= 1'b0;
            ch_p1   <= '0;
        end else if (can_load) begin
            vld_p1 <= xfer;
            if (xfer) begin
                data_p1 <= sel_data;
                last_p1 <= sel_last;
                ch_p1   <= grant;
            end
        end
    end

    assign bus.out_valid = vld_p1;
    assign bus.out_data  = data_p1;
    assign bus.out_last  = last_p1;
    assign bus.out_ch    = ch_p1;
endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed bench: a select-mode instance driven from a vector table and a
// round-robin instance exercised with hand-written multi-cycle sequences.
module tb_stream_mux_arb;
    localparam int WIDTH  = 17;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    logic clk = 1'b0;
    logic reset;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    always #5 clk = ~clk;

    stream_mux_arb_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus0 ();
    stream_mux_arb_if #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W)) bus1 ();

    stream_mux_arb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .MODE(0)) u_sel (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    stream_mux_arb #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .SEL_W(SEL_W), .MODE(1)) u_rr (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [3:0]  last;
        logic [1:0]  sel;
        logic        ordy;
        logic [67:0] data;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [16:0] exp_data;
        logic [1:0]  exp_ch;
        logic        exp_last;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic [3:0] v, input logic [3:0] l, input logic [1:0] s,
                                input logic r, input logic [16:0] d3, input logic [16:0] d2,
                                input logic [16:0] d1, input logic [16:0] d0,
                                input logic [3:0] er, input logic eo, input logic [16:0] ed,
                                input logic [1:0] ec, input logic el);
        vec_t t;
        t.valid    = v;
        t.last     = l;
        t.sel      = s;
        t.ordy     = r;
        t.data     = {d3, d2, d1, d0};
        t.exp_rdy  = er;
        t.exp_ov   = eo;
        t.exp_data = ed;
        t.exp_ch   = ec;
        t.exp_last = el;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // select-mode table: IDLE/select, packet lock, back-pressure, lock stall
        tbl[0]  = mk(4'b0100, 4'b0100, 2'd2, 1'b1, 17'h0, 17'h1ABCD, 17'h0, 17'h0, 4'b0100, 1'b1, 17'h1ABCD, 2'd2, 1'b1);
        tbl[1]  = mk(4'b0000, 4'b0000, 2'd3, 1'b1, 17'h0, 17'h0, 17'h0, 17'h0, 4'b0000, 1'b0, 17'h0, 2'd0, 1'b0);
        tbl[2]  = mk(4'b0010, 4'b0000, 2'd1, 1'b1, 17'h0, 17'h0, 17'h00001, 17'h0, 4'b0010, 1'b1, 17'h00001, 2'd1, 1'b0);
        tbl[3]  = mk(4'b0011, 4'b0001, 2'd0, 1'b1, 17'h0, 17'h0, 17'h00002, 17'h00AA0, 4'b0010, 1'b1, 17'h00002, 2'd1, 1'b0);
        tbl[4]  = mk(4'b0011, 4'b0011, 2'd0, 1'b1, 17'h0, 17'h0, 17'h00003, 17'h00AA0, 4'b0010, 1'b1, 17'h00003, 2'd1, 1'b1);
        tbl[5]  = mk(4'b0001, 4'b0001, 2'd0, 1'b1, 17'h0, 17'h0, 17'h0, 17'h00AA0, 4'b0001, 1'b1, 17'h00AA0, 2'd0, 1'b1);
        tbl[6]  = mk(4'b1000, 4'b1000, 2'd3, 1'b1, 17'h15555, 17'h0, 17'h0, 17'h0, 4'b1000, 1'b1, 17'h15555, 2'd3, 1'b1);
        for (int i = 7; i <= 10; i++)
            tbl[i] = mk(4'b1000, 4'b1000, 2'd3, 1'b0, 17'h0AAAA, 17'h0, 17'h0, 17'h0, 4'b0000, 1'b1, 17'h15555, 2'd3, 1'b1);
        tbl[11] = mk(4'b1000, 4'b1000, 2'd3, 1'b1, 17'h0AAAA, 17'h0, 17'h0, 17'h0, 4'b1000, 1'b1, 17'h0AAAA, 2'd3, 1'b1);
        tbl[12] = mk(4'b0100, 4'b0000, 2'd2, 1'b1, 17'h0, 17'h00007, 17'h0, 17'h0, 4'b0100, 1'b1, 17'h00007, 2'd2, 1'b0);
        tbl[13] = mk(4'b0001, 4'b0001, 2'd0, 1'b1, 17'h0, 17'h0, 17'h0, 17'h00AA0, 4'b0100, 1'b0, 17'h0, 2'd0, 1'b0);
        tbl[14] = mk(4'b0101, 4'b0101, 2'd0, 1'b1, 17'h0, 17'h00008, 17'h0, 17'h00AA0, 4'b0100, 1'b1, 17'h00008, 2'd2, 1'b1);
        tbl[15] = mk(4'b0001, 4'b0001, 2'd0, 1'b1, 17'h0, 17'h0, 17'h0, 17'h00AA0, 4'b0001, 1'b1, 17'h00AA0, 2'd0, 1'b1);

        reset          = 1'b1;
        bus0.in_valid  = '1;
        bus0.in_last   = '1;
        bus0.in_data   = '0;
        bus0.select    = '0;
        bus0.out_ready = 1'b1;
        bus1.in_valid  = '1;
        bus1.in_last   = '1;
        bus1.in_data   = {17'h00013, 17'h00012, 17'h00011, 17'h00010};
        bus1.select    = '0;
        bus1.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        reset         = 1'b0;
        bus0.in_valid = '0;
        check("rst sel out_valid", 32'(bus0.out_valid), 32'h0);
        check("rst sel out_data", 32'(bus0.out_data), 32'h0);
        check("rst rr out_valid", 32'(bus1.out_valid), 32'h0);
        check("rst rr out_data", 32'(bus1.out_data), 32'h0);
        check("rst rr out_ch", 32'(bus1.out_ch), 32'h0);
        #1;
        check("rr first in_ready", 32'(bus1.in_ready), 32'h1);

        // round-robin fairness with single-beat packets on every channel
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("rr beat%0d out_valid", i), 32'(bus1.out_valid), 32'h1);
            check($sformatf("rr beat%0d out_ch", i), 32'(bus1.out_ch), 32'(i % 4));
            check($sformatf("rr beat%0d out_data", i), 32'(bus1.out_data), 32'h10 + 32'(i % 4));
        end
        bus1.in_valid = '0;
        @(posedge clk);
        #1;
        check("rr drain out_valid", 32'(bus1.out_valid), 32'h0);

        for (int i = 0; i < 16; i++) begin
            bus0.in_valid  = tbl[i].valid;
            bus0.in_last   = tbl[i].last;
            bus0.select    = tbl[i].sel;
            bus0.out_ready = tbl[i].ordy;
            bus0.in_data   = tbl[i].data;
            #1;
            check($sformatf("vec%0d in_ready", i), 32'(bus0.in_ready), 32'(tbl[i].exp_rdy));
            @(posedge clk);
            #1;
            check($sformatf("vec%0d out_valid", i), 32'(bus0.out_valid), 32'(tbl[i].exp_ov));
            if (tbl[i].exp_ov) begin
                check($sformatf("vec%0d out_beat", i),
                      32'({bus0.out_last, bus0.out_ch, bus0.out_data}),
                      32'({tbl[i].exp_last, tbl[i].exp_ch, tbl[i].exp_data}));
            end
        end
        bus0.in_valid = '0;

        // reset in the middle of a locked packet on the round-robin instance
        bus1.in_valid = 4'b0100;
        bus1.in_last  = 4'b0000;
        bus1.in_data  = {17'h0, 17'h00222, 17'h0, 17'h0};
        #1;
        check("midrst lock in_ready", 32'(bus1.in_ready), 32'h4);
        @(posedge clk);
        #1;
        check("midrst lock out_ch", 32'(bus1.out_ch), 32'h2);
        check("midrst lock out_last", 32'(bus1.out_last), 32'h0);
        reset         = 1'b1;
        bus1.in_valid = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midrst out_valid", 32'(bus1.out_valid), 32'h0);
        bus1.in_valid = 4'b0101;
        bus1.in_last  = 4'b0101;
        bus1.in_data  = {17'h0, 17'h00222, 17'h0, 17'h00300};
        #1;
        check("midrst regrant in_ready", 32'(bus1.in_ready), 32'h1);
        @(posedge clk);
        #1;
        check("midrst first out_ch", 32'(bus1.out_ch), 32'h0);
        check("midrst first out_data", 32'(bus1.out_data), 32'h300);
        @(posedge clk);
        #1;
        check("midrst second out_ch", 32'(bus1.out_ch), 32'h2);
        check("midrst second out_data", 32'(bus1.out_data), 32'h222);
        check("midrst second out_last", 32'(bus1.out_last), 32'h1);
        bus1.in_valid = '0;
        @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
